// File: rtl/lfsr_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and default taps for the LFSR stream controller.
package lfsr_ctrl_pkg;

   localparam logic [7:0] OP_TAPS = 8'h01;
   localparam logic [7:0] OP_CLR  = 8'h02;
   localparam logic [7:0] OP_GEN  = 8'h03;

   localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TAPS  = 3'd1,
      COUNT = 3'd2,
      STEP  = 3'd3,
      LOAD  = 3'd4,
      SEND  = 3'd5
   } state_t;

endpackage

// File: rtl/lfsr_stream_ctrl.sv
// Command sequencer for the LFSR: taps load, clear, and K-byte generation, 3 cycles per byte.
// tx_valid holds with stable tx_data until tx_ready; rx bytes arriving mid-stream are dropped.
module lfsr_stream_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int             N            = 16,
   parameter logic [N-1:0]   DEFAULT_TAPS = N'(DEFAULT_TAPS_16)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   input  logic [N-1:0] lfsr_random,
   output logic         lfsr_ena,
   output logic [N-1:0] lfsr_taps,
   output logic         lfsr_clr,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         drop
);

   localparam int             NBYTES    = N / 8;
   localparam int             BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

   state_t         state, state_nxt;
   logic [N-1:0]   taps_sh;
   logic [N-1:0]   taps_shifted;
   logic [BCW-1:0] byte_cnt;
   logic [8:0]     cnt;

   logic           taps_byte;
   logic           taps_last;
   logic           count_load;
   logic           load_byte;
   logic           handshake;
   logic           clr_req;
   logic           drop_set;

   // Only the low byte of the LFSR is streamed; fold the rest to keep lint quiet.
   logic           unused_random;
   assign unused_random = ^lfsr_random;

   assign taps_shifted = N'({taps_sh, rx_data});

   assign lfsr_ena = (state == STEP);
   assign tx_valid = (state == SEND);
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      taps_byte  = 1'b0;
      taps_last  = 1'b0;
      count_load = 1'b0;
      load_byte  = 1'b0;
      handshake  = 1'b0;
      clr_req    = 1'b0;
      drop_set   = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == OP_TAPS) begin
                  state_nxt = TAPS;
               end else if (rx_data == OP_CLR) begin
                  clr_req = 1'b1;
               end else if (rx_data == OP_GEN) begin
                  state_nxt = COUNT;
               end
            end
         end
         TAPS: begin
            if (rx_valid) begin
               taps_byte = 1'b1;
               if (byte_cnt == LAST_BYTE) begin
                  taps_last = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         COUNT: begin
            if (rx_valid) begin
               count_load = 1'b1;
               state_nxt  = STEP;
            end
         end
         STEP: begin
            drop_set  = rx_valid;
            state_nxt = LOAD;
         end
         LOAD: begin
            drop_set  = rx_valid;
            load_byte = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            drop_set = rx_valid;
            if (tx_ready) begin
               handshake = 1'b1;
               state_nxt = (cnt == 9'd1) ? IDLE : STEP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lfsr_taps <= DEFAULT_TAPS;
         taps_sh   <= '0;
         byte_cnt  <= '0;
         cnt       <= '0;
         tx_data   <= '0;
         lfsr_clr  <= 1'b0;
         drop      <= 1'b0;
      end else begin
         state    <= state_nxt;
         lfsr_clr <= clr_req;
         if (drop_set) begin
            drop <= 1'b1;
         end
         // Taps are committed only on the last operand byte so the LFSR never sees a half-loaded function.
         if (taps_byte) begin
            taps_sh  <= taps_shifted;
            byte_cnt <= taps_last ? '0 : byte_cnt + 1'b1;
            if (taps_last) begin
               lfsr_taps <= taps_shifted;
            end
         end
         if (count_load) begin
            cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
         end
         if (load_byte) begin
            tx_data <= lfsr_random[7:0];
         end
         if (handshake) begin
            cnt <= cnt - 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Directed bench for lfsr_stream_ctrl with a behavioural Fibonacci LFSR closing the loop.
module tb_lfsr_stream_ctrl;
   import lfsr_ctrl_pkg::*;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic [N-1:0] lfsr_random;
   logic         lfsr_ena;
   logic [N-1:0] lfsr_taps;
   logic         lfsr_clr;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic         drop;

   int vectors     = 0;
   int miscompares = 0;
   int ena_cnt     = 0;
   int hs_cnt      = 0;
   int clr_cnt     = 0;
   int valid_viol  = 0;
   logic last_v    = 1'b0;
   logic last_hs   = 1'b0;
   logic last_rst  = 1'b1;

   lfsr_stream_ctrl #(.N(N), .DEFAULT_TAPS(16'hB400)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .lfsr_random (lfsr_random),
      .lfsr_ena    (lfsr_ena),
      .lfsr_taps   (lfsr_taps),
      .lfsr_clr    (lfsr_clr),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .drop        (drop)
   );

   always #5 clk = ~clk;

   // Stand-in for the separate LFSR instance: seed 1, shifts left, feedback = parity of tapped bits.
   always @(posedge clk) begin
      if (rst | lfsr_clr)
         lfsr_random <= 16'h0001;
      else if (lfsr_ena)
         lfsr_random <= {lfsr_random[N-2:0], ^(lfsr_random & lfsr_taps)};
   end

   always @(posedge clk) begin
      if (lfsr_ena) ena_cnt++;
      if (tx_valid && tx_ready) hs_cnt++;
      if (lfsr_clr) clr_cnt++;
      if (last_v && !last_hs && !last_rst && !tx_valid) valid_viol++;
      last_v   = tx_valid;
      last_hs  = tx_valid & tx_ready;
      last_rst = rst;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!tx_valid && n < budget) begin
         tick();
         n++;
      end
      chk(tag, tx_valid, 1);
   endtask

   initial begin
      int e0, h0, c0, n;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (10) tick();

      chk("rst_taps", lfsr_taps, 16'hB400);
      chk("rst_ena", lfsr_ena, 0);
      chk("rst_clr", lfsr_clr, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop, 0);

      send(8'h7F);
      chk("unknown_busy", busy, 0);
      chk("unknown_drop", drop, 0);

      send(OP_TAPS);
      chk("taps_busy", busy, 1);
      send(8'h12);
      chk("taps_mid_busy", busy, 1);
      chk("taps_atomic", lfsr_taps, 16'hB400);
      send(8'h34);
      chk("taps_1234", lfsr_taps, 16'h1234);
      chk("taps_idle", busy, 0);
      send(OP_TAPS);
      send(8'hB4);
      send(8'h00);
      chk("taps_b400", lfsr_taps, 16'hB400);

      send(OP_CLR);
      chk("clr_pulse", lfsr_clr, 1);
      chk("clr_no_ena", lfsr_ena, 0);
      chk("clr_busy", busy, 0);
      tick();
      chk("clr_one_cycle", lfsr_clr, 0);

      // K=3 stream from seed 1, taps B400: 0002, 0004, 0008.
      tx_ready = 1'b1;
      e0 = ena_cnt;
      h0 = hs_cnt;
      send(OP_GEN);
      chk("gen_count_busy", busy, 1);
      send(8'h03);
      chk("gen_step_ena", lfsr_ena, 1);
      chk("gen_step_novalid", tx_valid, 0);
      tick();
      chk("gen_load_noena", lfsr_ena, 0);
      tick();
      chk("gen_valid_2edges", tx_valid, 1);
      chk("gen_byte0", tx_data, 8'h02);
      repeat (3) tick();
      chk("gen_byte1_valid", tx_valid, 1);
      chk("gen_byte1", tx_data, 8'h04);
      repeat (3) tick();
      chk("gen_byte2", tx_data, 8'h08);
      tick();
      chk("gen_idle", busy, 0);
      chk("gen_ena_pulses", ena_cnt - e0, 3);
      chk("gen_handshakes", hs_cnt - h0, 3);

      // Backpressure: state 0008 -> 0010 -> 0020.
      tx_ready = 1'b0;
      e0 = ena_cnt;
      h0 = hs_cnt;
      send(OP_GEN);
      send(8'h02);
      tick();
      tick();
      chk("bp_valid", tx_valid, 1);
      chk("bp_byte0", tx_data, 8'h10);
      repeat (20) tick();
      chk("bp_held_valid", tx_valid, 1);
      chk("bp_held_data", tx_data, 8'h10);
      chk("bp_no_extra_ena", ena_cnt - e0, 1);
      tx_ready = 1'b1;
      tick();
      wait_valid("bp_second_valid", 10);
      chk("bp_byte1", tx_data, 8'h20);
      tick();
      chk("bp_idle", busy, 0);
      chk("bp_ena_pulses", ena_cnt - e0, 2);
      chk("bp_handshakes", hs_cnt - h0, 2);

      // Count byte 0 means 256 bytes, 3 cycles each.
      e0 = ena_cnt;
      h0 = hs_cnt;
      send(OP_GEN);
      send(8'h00);
      n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      chk("k0_cycles", n, 768);
      chk("k0_ena_pulses", ena_cnt - e0, 256);
      chk("k0_handshakes", hs_cnt - h0, 256);

      // A CLR opcode arriving during SEND must be dropped.
      send(OP_CLR);
      chk("drop_pre_clr", lfsr_clr, 1);
      tx_ready = 1'b0;
      send(OP_GEN);
      c0 = clr_cnt;
      send(8'h01);
      tick();
      tick();
      chk("drop_valid", tx_valid, 1);
      chk("drop_byte", tx_data, 8'h02);
      send(OP_CLR);
      chk("drop_flag", drop, 1);
      chk("drop_no_clr", lfsr_clr, 0);
      chk("drop_still_valid", tx_valid, 1);
      chk("drop_data_stable", tx_data, 8'h02);
      tx_ready = 1'b1;
      tick();
      chk("drop_stream_done", busy, 0);
      chk("drop_clr_count", clr_cnt - c0, 0);
      chk("drop_sticky", drop, 1);

      // Reset in the middle of a taps load.
      send(OP_TAPS);
      send(8'h12);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_taps", lfsr_taps, 16'hB400);
      chk("midrst_busy", busy, 0);
      chk("midrst_drop", drop, 0);
      send(OP_GEN);
      send(8'h01);
      wait_valid("midrst_gen_valid", 10);
      chk("midrst_byte", tx_data, 8'h02);
      tick();
      chk("midrst_idle", busy, 0);
      send(OP_TAPS);
      send(8'hAB);
      send(8'hCD);
      chk("midrst_taps_abcd", lfsr_taps, 16'hABCD);

      chk("tx_valid_hold", valid_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_ctrl.md
# lfsr_stream_ctrl

Command-driven sequencer for the n-bit Fibonacci LFSR in the LFSR+UART design. Parses command bytes from the UART receiver, configures the LFSR feedback taps, clears it on request, and steps it on demand to stream K pseudo-random bytes to the UART transmitter with a valid/ready handshake. It owns the LFSR's `ena`, `feedfunc` and clear inputs; the LFSR itself stays a separate instance.

## Interface

- `N`, 16: LFSR width. It must be a multiple of 8 and at least 8.
- `DEFAULT_TAPS`, 16'hB400: reset value of `lfsr_taps`. Bit i set means `random[i]` is tapped (x^16+x^14+x^13+x^11).
- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received command/operand byte.
- `rx_valid`  in  1  one-cycle strobe marking `rx_data` valid.
- `lfsr_random`  in  N  LFSR state output.
- `lfsr_ena`  out  1  LFSR step enable.
- `lfsr_taps`  out  N  LFSR feedback function.
- `lfsr_clr`  out  1  one-cycle clear pulse. Integrator ties the LFSR reset to `rst | lfsr_clr`.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte.
- `busy`  out  1  high in every state other than IDLE.
- `drop`  out  1  sticky flag: an rx byte was discarded during STEP, LOAD or SEND.

## Operation

- **Opcodes** (all are `localparam` values):
  - `OP_TAPS`=8'h01: followed by N/8 bytes, MSB byte first.
  - `OP_CLR`=8'h02: no operand.
  - `OP_GEN`=8'h03: followed by one count byte K. K=0 means 256.
- **Unknown opcode in IDLE:** ignored. State stays IDLE and `drop` is not set.
- **States and transitions:**
  - IDLE: `rx_valid` with `OP_TAPS` goes to TAPS. `OP_CLR` pulses `lfsr_clr` for the following cycle and stays in IDLE. `OP_GEN` goes to COUNT.
  - TAPS: each `rx_valid` shifts the byte into the shadow register `taps_sh` (left shift by 8). Byte counter counts 0..N/8-1. On the last byte, `lfsr_taps <= {taps_sh[N-9:0], rx_data}` (atomic update) and the state returns to IDLE.
  - COUNT: on `rx_valid`, `cnt <= (rx_data==0) ? 256 : rx_data` (9-bit) and the state goes to STEP.
  - STEP: `lfsr_ena`=1 for exactly this cycle, then LOAD.
  - LOAD: `tx_data <= lfsr_random[7:0]`, then SEND.
  - SEND: `tx_valid`=1 and `tx_data` is held stable until `tx_valid & tx_ready`. On the handshake, `cnt <= cnt-1`. If `cnt==1`, go to IDLE; otherwise go to STEP.
- **Discarded bytes:** `rx_valid` in STEP, LOAD or SEND discards the byte and sets `drop`. `drop` is cleared only by `rst`.
- **Waiting in TAPS or COUNT:** no timeout. These states wait indefinitely for operand bytes.
- **Reset values:** state=IDLE, `lfsr_taps`=`DEFAULT_TAPS`, `lfsr_ena`=0, `lfsr_clr`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `drop`=0, `cnt`=0.
- **Reset mid-operation:** `rst` in any state aborts the operation in the same edge. Partially received taps are discarded and the `lfsr_taps` reset value applies.

## Timing

- **`OP_GEN` latency:** count byte sampled at edge e0 → STEP in cycle e0..e1 → LOAD e1..e2 → `tx_valid` high from e2. First byte = `lfsr_random[7:0]` after one step.
- **Back-to-back bytes:** with `tx_ready` held high, a new byte is offered every 3 cycles (STEP, LOAD, SEND). K bytes take 3K cycles.
- **`OP_CLR`:** `lfsr_clr` is high in the cycle after the opcode edge. The controller never asserts `lfsr_ena` in that cycle.
- **`OP_TAPS`:** `lfsr_taps` changes on the edge that samples the last operand byte and is valid from the next cycle.
- **`lfsr_ena`:** never high outside STEP. Exactly K pulses per `OP_GEN`.
- **`tx_valid`:** never deasserts without a handshake, except on `rst`.

## Structure

- **Shared package `lfsr_ctrl_pkg`:** opcode constants `OP_TAPS`, `OP_CLR`, `OP_GEN`; state encoding IDLE/TAPS/COUNT/STEP/LOAD/SEND (3-bit); `DEFAULT_TAPS_16`.
- **Sub-modules:** none. This is one FSM with a taps shadow register, a byte counter and a 9-bit count. The LFSR and UART are instantiated by the top level.

## Test plan

- **Reset defaults:** reset, then idle 10 cycles → `lfsr_taps`=16'hB400, all outputs 0, `busy`=0.
- **Clear then generate:** send `01`,`B4`,`00` then `02` then `03`,`03` with `tx_ready`=1 → exactly 3 `lfsr_ena` pulses. The tx bytes equal the low bytes of the reference LFSR model from seed 1 (first byte 8'h02). `tx_valid` rises 2 edges after the count byte.
- **Backpressure:** `03`,`02`, hold `tx_ready`=0 for 20 cycles → `tx_valid`=1 with `tx_data` stable and no extra `lfsr_ena`. Release → 2 bytes, then IDLE.
- **Count zero:** `03`,`00` → exactly 256 handshakes and 256 `lfsr_ena` pulses.
- **Bytes during generation:** `rx_valid` with `02` during SEND → byte ignored, no `lfsr_clr`, `drop`=1, stream continues.
- **Reset mid-operation:** `rst` after the first taps byte of `01`,`12`,… → `lfsr_taps`=16'hB400, state IDLE, next `03`,`01` works normally.
